// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
//
// Purpose:
//   Shares the single write port of the 32x32 register file between NREQ
//   writeback requesters (e.g. ALU, load unit, mul/div unit). Arbitration is
//   round-robin and combinational. The granted write is registered and
//   presented to the register file one cycle after the handshake. Writes to
//   register 0 complete their handshake but never raise regWrite. A saturating
//   counter records cycles in which two or more requesters competed.
//
// Ports:
//   clk             in   clock, rising edge
//   reset           in   asynchronous active-high reset
//   arb_en          in   1 = grants may be issued, 0 = arbitration frozen
//   req_valid       in   [NREQ]     per-requester request valid
//   req_reg         in   [NREQ*AW]  requester i destination at [i*AW +: AW]
//   req_data        in   [NREQ*DW]  requester i data at [i*DW +: DW]
//   req_ready       out  [NREQ]     one-hot grant (combinational)
//   regWrite        out  register file write enable (registered)
//   writeReg        out  [AW]       register file write address (registered)
//   writeData       out  [DW]       register file write data (registered)
//   grant_id        out  [IW]       requester owning the current output write
//   contention_cnt  out  [CW]       saturating count of contended cycles
// -----------------------------------------------------------------------------
module regfile_wb_arbiter #(
  parameter int NREQ = 3,
  parameter int DW   = 32,
  parameter int AW   = 5,
  parameter int CW   = 16,
  localparam int IW  = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               arb_en,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*AW-1:0] req_reg,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  output logic               regWrite,
  output logic [AW-1:0]      writeReg,
  output logic [DW-1:0]      writeData,
  output logic [IW-1:0]      grant_id,
  output logic [CW-1:0]      contention_cnt
);

  // Registered state
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic          we_q;
  logic [AW-1:0] wreg_q;
  logic [DW-1:0] wdata_q;
  logic [IW-1:0] gid_q;
  logic [CW-1:0] cnt_q;

  // Arbitration results
  logic [NREQ-1:0] hi_mask;
  logic [NREQ-1:0] sel_vec;
  logic            gnt_found;
  logic [IW-1:0]   gnt_idx;
  logic [AW-1:0]   sel_reg;
  logic [DW-1:0]   sel_data;
  logic [3:0]      vcnt;
  logic            multi_valid;

  // Round-robin search: requests at or above rr_ptr take priority; if none
  // exist there the search wraps and the lowest valid index overall wins.
  always_comb begin
    hi_mask   = '0;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      hi_mask[i] = req_valid[i] && (IW'(i) >= rr_ptr_q);
    end
    sel_vec = (|hi_mask) ? hi_mask : req_valid;
    for (int i = 0; i < NREQ; i++) begin
      if (!gnt_found && sel_vec[i]) begin
        gnt_found = 1'b1;
        gnt_idx   = IW'(i);
      end
    end
    // Grants are suppressed while frozen or held in reset; req_ready is
    // combinational so it must fall with reset without waiting for a clock.
    if (reset || !arb_en) begin
      gnt_found = 1'b0;
    end
  end

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = gnt_found && (gnt_idx == IW'(i));
    end
  end

  // Only the granted requester's fields are selected, so unused (possibly X)
  // request fields never reach the output registers.
  always_comb begin
    sel_reg  = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_idx == IW'(i)) begin
        sel_reg  = req_reg[i*AW +: AW];
        sel_data = req_data[i*DW +: DW];
      end
    end
  end

  always_comb begin
    vcnt = '0;
    for (int i = 0; i < NREQ; i++) begin
      vcnt = vcnt + 4'(req_valid[i]);
    end
    multi_valid = (vcnt >= 4'd2);
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (gnt_found) begin
      rr_ptr_d = (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + IW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q <= '0;
      we_q     <= 1'b0;
      wreg_q   <= '0;
      wdata_q  <= '0;
      gid_q    <= '0;
      cnt_q    <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      if (gnt_found) begin
        // Register 0 is hardwired: the handshake completes but no write fires.
        we_q    <= (sel_reg != '0);
        wreg_q  <= sel_reg;
        wdata_q <= sel_data;
        gid_q   <= gnt_idx;
      end else begin
        we_q <= 1'b0;
      end
      if (arb_en && multi_valid && (cnt_q != {CW{1'b1}})) begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign regWrite       = we_q;
  assign writeReg       = wreg_q;
  assign writeData      = wdata_q;
  assign grant_id       = gid_q;
  assign contention_cnt = cnt_q;

endmodule
